// File: rtl/call_return_unit_pkg.sv
// Shared types and constants for the call/return sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package call_return_unit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CALL_PUSH,
        CALL_JUMP,
        RET_POP,
        RET_WAIT,
        RET_LOAD
    } state_e;

endpackage

// File: rtl/call_return_unit_depth_counter.sv
// Tracks return-stack occupancy; flags full and empty for the sequencer.
// Latency: depth updates on the clk edge after inc/dec is seen.
// Backpressure: inc at full and dec at empty are ignored, so depth never wraps.
// Ports: clk/rst_n, inc/dec in; depth, full, empty out (all from the depth register).
module depth_counter #(
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign full  = (depth_q == DEPTH_W'(MAX_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (inc && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/call_return_unit.sv
// CALL/RET sequencer driving an external return-address stack and the PC load port.
// Latency: CALL push at +1 and jump/done at +2; RET pop at +1 and load/done at +3 cycles.
// Backpressure: requests while busy are dropped (no queuing); full/empty requests set sticky faults.
// Ports: start_call/start_ret/pc_in/target/stack_out/clear_fault in; stack_push/stack_pop,
//        bus_out/bus_drive, pc_load/pc_value, busy/done, overflow/underflow, depth out.
module call_return_unit
    import call_return_unit_pkg::*;
#(
    parameter int MAX_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_call,
    input  logic                           start_ret,
    input  logic [DATA_W-1:0]              pc_in,
    input  logic [DATA_W-1:0]              target,
    input  logic [DATA_W-1:0]              stack_out,
    input  logic                           clear_fault,
    output logic                           stack_push,
    output logic                           stack_pop,
    output logic [DATA_W-1:0]              bus_out,
    output logic                           bus_drive,
    output logic                           pc_load,
    output logic [DATA_W-1:0]              pc_value,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           underflow,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ret_addr_q, ret_addr_d;
    logic [DATA_W-1:0]   target_q, target_d;
    logic [DATA_W-1:0]   ret_val_q, ret_val_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                ovf_set, unf_set;
    logic                full, empty;

    depth_counter #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst_n (reset),
        .inc   (state_q == CALL_JUMP),
        .dec   (state_q == RET_LOAD),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        ret_addr_d = ret_addr_q;
        target_d   = target_q;
        ret_val_d  = ret_val_q;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (state_q)
            IDLE: begin
                // CALL has priority; a simultaneous RET is simply dropped.
                if (start_call) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        ret_addr_d = pc_in + 8'd1;
                        target_d   = target;
                        state_d    = CALL_PUSH;
                    end
                end else if (start_ret) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        state_d = RET_POP;
                    end
                end
            end
            CALL_PUSH: state_d = CALL_JUMP;
            CALL_JUMP: state_d = IDLE;
            RET_POP:   state_d = RET_WAIT;
            RET_WAIT: begin
                // Stack read data is valid the cycle after the pop strobe.
                ret_val_d = stack_out;
                state_d   = RET_LOAD;
            end
            RET_LOAD:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // A fresh fault outranks a coincident clear.
        overflow_d  = ovf_set | (overflow_q & ~clear_fault);
        underflow_d = unf_set | (underflow_q & ~clear_fault);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ret_addr_q  <= '0;
            target_q    <= '0;
            ret_val_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_addr_q  <= ret_addr_d;
            target_q    <= target_d;
            ret_val_q   <= ret_val_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs decode registered state only, so reset zeroes them immediately.
    assign stack_push = (state_q == CALL_PUSH);
    assign stack_pop  = (state_q == RET_POP);
    assign bus_drive  = (state_q == CALL_PUSH);
    assign bus_out    = (state_q == CALL_PUSH) ? ret_addr_q : '0;
    assign pc_load    = (state_q == CALL_JUMP) || (state_q == RET_LOAD);
    assign done       = pc_load;
    assign pc_value   = (state_q == CALL_JUMP) ? target_q :
                        (state_q == RET_LOAD)  ? ret_val_q : '0;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_call_return_unit.sv
// Randomized scoreboard bench for call_return_unit with a queue-based stack model.
// Latency: checks push at +1, CALL load at +2, pop at +1, RET load at +3 cycles.
// Backpressure: injects requests while busy and expects them to be ignored.
module tb_call_return_unit;

    localparam int MAXD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_call = 1'b0;
    logic       start_ret = 1'b0;
    logic       clear_fault = 1'b0;
    logic [7:0] pc_in = '0;
    logic [7:0] target = '0;
    logic [7:0] stack_out = '0;
    logic       stack_push, stack_pop, bus_drive, pc_load, busy, done, overflow, underflow;
    logic [7:0] bus_out, pc_value;
    logic [4:0] depth;

    call_return_unit #(.MAX_DEPTH(MAXD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_call  (start_call),
        .start_ret   (start_ret),
        .pc_in       (pc_in),
        .target      (target),
        .stack_out   (stack_out),
        .clear_fault (clear_fault),
        .stack_push  (stack_push),
        .stack_pop   (stack_pop),
        .bus_out     (bus_out),
        .bus_drive   (bus_drive),
        .pc_load     (pc_load),
        .pc_value    (pc_value),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .underflow   (underflow),
        .depth       (depth)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: return addresses the program expects back, plus sticky flags.
    logic [7:0] model_stack[$];
    logic       model_ovf = 1'b0;
    logic       model_unf = 1'b0;
    // Scoreboard: expected push data and PC loads, in order.
    logic [7:0] push_q[$];
    logic [7:0] load_q[$];
    int         pops_pending = 0;
    // External stack memory attached to the DUT.
    logic [7:0] mem[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs on the falling edge, pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (!reset) begin
            mem.delete();
        end else begin
            check("push_pop_exclusive", stack_push & stack_pop, 0);
            if (!bus_drive) check("bus_idle_zero", bus_out, 0);
            if (done) check("done_has_load", pc_load, 1);
            if (stack_push) begin
                check("push_expected", push_q.size() > 0, 1);
                check("push_bus_drive", bus_drive, 1);
                if (push_q.size() > 0) check("push_data", bus_out, push_q.pop_front());
                mem.push_back(bus_out);
            end
            if (stack_pop) begin
                check("pop_expected", pops_pending > 0, 1);
                if (pops_pending > 0) pops_pending--;
                if (mem.size() > 0) stack_out = mem.pop_back();
            end
            if (pc_load) begin
                check("load_expected", load_q.size() > 0, 1);
                check("load_done", done, 1);
                if (load_q.size() > 0) check("pc_value", pc_value, load_q.pop_front());
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_overflow"}, overflow, model_ovf);
        check({tag, "_underflow"}, underflow, model_unf);
        check({tag, "_depth"}, depth, model_stack.size());
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt, input bit also_ret, input bit noise);
        logic [7:0] ra;
        start_call = 1'b1;
        start_ret  = also_ret;
        pc_in      = pc;
        target     = tgt;
        @(posedge clk); #1;
        start_call = 1'b0;
        start_ret  = 1'b0;
        if (model_stack.size() < MAXD) begin
            ra = pc + 8'd1;
            model_stack.push_back(ra);
            push_q.push_back(ra);
            load_q.push_back(tgt);
            check("call_push_c1", stack_push, 1);
            check("call_nopop_c1", stack_pop, 0);
            check("call_busy_c1", busy, 1);
            check("call_noload_c1", pc_load, 0);
            if (noise) begin
                start_call = 1'b1;
                start_ret  = 1'b1;
                pc_in      = 8'($urandom);
            end
            @(posedge clk); #1;
            start_call = 1'b0;
            start_ret  = 1'b0;
            check("call_load_c2", pc_load, 1);
            check("call_done_c2", done, 1);
            check("call_nopush_c2", stack_push, 0);
            check("call_nopop_c2", stack_pop, 0);
            @(posedge clk); #1;
            check("call_idle_c3", busy, 0);
            check_flags("call");
        end else begin
            model_ovf = 1'b1;
            check("ovf_nopush", stack_push, 0);
            check("ovf_idle", busy, 0);
            check_flags("ovf");
        end
    endtask

    task automatic do_ret(input bit noise);
        start_ret = 1'b1;
        @(posedge clk); #1;
        start_ret = 1'b0;
        if (model_stack.size() > 0) begin
            load_q.push_back(model_stack.pop_back());
            pops_pending++;
            check("ret_pop_c1", stack_pop, 1);
            check("ret_busy_c1", busy, 1);
            if (noise) begin
                start_call = 1'b1;
                pc_in      = 8'($urandom);
            end
            @(posedge clk); #1;
            start_call = 1'b0;
            check("ret_pop_once_c2", stack_pop, 0);
            check("ret_noload_c2", pc_load, 0);
            @(posedge clk); #1;
            check("ret_load_c3", pc_load, 1);
            check("ret_done_c3", done, 1);
            @(posedge clk); #1;
            check("ret_idle_c4", busy, 0);
            check_flags("ret");
        end else begin
            model_unf = 1'b1;
            check("unf_nopop", stack_pop, 0);
            check("unf_idle", busy, 0);
            check_flags("unf");
        end
    endtask

    task automatic do_clear(input bit with_ret);
        clear_fault = 1'b1;
        start_ret   = with_ret;
        @(posedge clk); #1;
        clear_fault = 1'b0;
        start_ret   = 1'b0;
        model_ovf   = 1'b0;
        model_unf   = with_ret && (model_stack.size() == 0);
        check_flags("clear");
    endtask

    // Abort a RET sequence by asserting reset while it waits for stack data.
    task automatic do_ret_reset();
        start_ret = 1'b1;
        @(posedge clk); #1;
        start_ret = 1'b0;
        pops_pending++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_stack.delete();
        push_q.delete();
        load_q.delete();
        pops_pending = 0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_value", pc_value, 0);
        check_flags("rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_no_load", pc_load, 0);
        check("rst_hold_no_pop", stack_pop, 0);
        // Release reset and issue a CALL in the very first cycle.
        reset = 1'b1;
        do_call(8'h20, 8'h60, 1'b0, 1'b0);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_depth", depth, 0);
        check("reset_ovf", overflow, 0);
        check("reset_unf", underflow, 0);
        check("reset_push", stack_push, 0);
        check("reset_pop", stack_pop, 0);
        check("reset_bus_out", bus_out, 0);
        check("reset_bus_drive", bus_drive, 0);
        check("reset_pc_load", pc_load, 0);
        check("reset_pc_value", pc_value, 0);
        check("reset_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        do_call(8'h10, 8'h40, 1'b0, 1'b0);
        do_ret(1'b0);
        do_call(8'hFF, 8'h80, 1'b0, 1'b0);
        do_ret(1'b0);

        for (int i = 0; i < MAXD; i++) do_call(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        do_call(8'h33, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < MAXD; i++) do_ret(1'b0);
        do_ret(1'b0);
        do_clear(1'b0);
        do_ret(1'b0);
        do_clear(1'b1);
        do_clear(1'b0);

        do_call(8'h50, 8'h70, 1'b1, 1'b0);
        do_ret(1'b0);
        do_call(8'h05, 8'h90, 1'b0, 1'b0);
        do_ret_reset();
        do_ret(1'b0);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)      do_call(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            else if (r < 9) do_ret($urandom_range(0, 1) == 1);
            else            do_clear(1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("push_q_drained", push_q.size(), 0);
        check("load_q_drained", load_q.size(), 0);
        check("pops_drained", pops_pending, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
